// File: rtl/ser_mux_sched_if.sv
// Parallel-word input handshake for the serializer scheduler.
// The master drives data/valid; the scheduler (slave) answers with ready.
interface ser_mux_sched_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_mux_sched.sv
// Serializer mux-tree scheduler: buffers one parallel word and streams words
// LSB-first, one bit per clk, with no gap between back-to-back words.
module ser_mux_sched #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   ser_mux_sched_if.slave           s_in,
   input  logic                     en,
   output logic [$clog2(WIDTH)-1:0] mux_sel,
   output logic                     ser_out,
   output logic                     ser_valid,
   output logic                     word_start,
   output logic                     underflow
);
   localparam int unsigned SEL_W = $clog2(WIDTH);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic [SEL_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_active;
   logic [WIDTH-1:0] r_pend;
   logic             r_pend_full;

   logic w_run;
   logic w_last;
   logic w_pop;
   logic w_xfer;

   assign w_run  = (r_state == S_RUN);
   assign w_last = w_run && (r_cnt == LAST);
   // en only matters at a word boundary: in IDLE or on the last bit of a word
   assign w_pop  = en && r_pend_full && (!w_run || w_last);

   assign s_in.in_ready = !rst && (!r_pend_full || w_pop);
   assign w_xfer        = s_in.in_valid && s_in.in_ready;

   assign mux_sel    = w_run ? r_cnt : '0;
   assign ser_out    = w_run ? r_active[r_cnt] : 1'b0;
   assign ser_valid  = w_run;
   assign word_start = w_run && (r_cnt == '0);
   assign underflow  = w_last && en && !r_pend_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_active    <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_active <= r_pend;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (w_pop) begin
                  r_active <= r_pend;
                  r_cnt    <= r_cnt + 1'b1;
               end else begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A transfer in the same cycle as a pop refills pend, keeping it full
         if (w_xfer) begin
            r_pend      <= s_in.in_data;
            r_pend_full <= 1'b1;
         end else if (w_pop) begin
            r_pend_full <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ser_mux_sched.sv
// Directed self-checking bench for ser_mux_sched with WIDTH=8.
module tb_ser_mux_sched;
   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] mux_sel;
   logic       ser_out;
   logic       ser_valid;
   logic       word_start;
   logic       underflow;

   int unsigned n_assert;
   int unsigned n_fail;

   ser_mux_sched_if #(.WIDTH(8)) bus ();

   ser_mux_sched #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_in       (bus.slave),
      .en         (en),
      .mux_sel    (mux_sel),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .word_start (word_start),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ser_valid"}, 32'(ser_valid), 0);
      chk({tag, ".mux_sel"}, 32'(mux_sel), 0);
      chk({tag, ".ser_out"}, 32'(ser_out), 0);
      chk({tag, ".word_start"}, 32'(word_start), 0);
      chk({tag, ".underflow"}, 32'(underflow), 0);
   endtask

   logic [23:0] s3;
   logic [15:0] s5;
   logic [7:0]  w2;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1; en = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 8'h55;

      // 1 reset
      tick(); tick(); tick();
      chk("rst.in_ready", 32'(bus.in_ready), 0);
      chk_idle("rst");
      rst = 1'b0; bus.in_valid = 1'b0;
      tick();
      #1;
      chk_idle("post_rst");
      chk("post_rst.in_ready", 32'(bus.in_ready), 1);

      // 2 single word A5
      w2 = 8'hA5;
      en = 1'b1; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("t2.wait_valid", 32'(ser_valid), 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t2.valid", 32'(ser_valid), 1);
         chk("t2.mux_sel", 32'(mux_sel), 32'(i));
         chk("t2.ser_out", 32'(ser_out), 32'(w2[i]));
         chk("t2.word_start", 32'(word_start), 32'(i == 0));
         chk("t2.underflow", 32'(underflow), 32'(i == 7));
         tick();
      end
      chk_idle("t2.end");

      // 3 back-to-back 0F, F0, 3C
      s3 = 24'h3CF00F;
      bus.in_data = 8'h0F; bus.in_valid = 1'b1;
      tick();
      bus.in_data = 8'hF0;
      #1;
      chk("t3.ready_pop0", 32'(bus.in_ready), 1);
      tick();
      bus.in_data = 8'h3C;
      for (int i = 0; i < 24; i++) begin
         if (i == 8) bus.in_valid = 1'b0;
         #1;
         chk("t3.valid", 32'(ser_valid), 1);
         chk("t3.mux_sel", 32'(mux_sel), 32'(i % 8));
         chk("t3.ser_out", 32'(ser_out), 32'(s3[i]));
         chk("t3.word_start", 32'(word_start), 32'((i % 8) == 0));
         chk("t3.in_ready", 32'(bus.in_ready), 32'(i == 7 || i == 15 || i >= 16));
         chk("t3.underflow", 32'(underflow), 32'(i == 23));
         tick();
      end
      chk_idle("t3.end");

      // 4 en drop mid-word with a word pending
      bus.in_data = 8'hFF; bus.in_valid = 1'b1;
      tick();
      bus.in_data = 8'h00;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t4.mux_sel", 32'(mux_sel), 32'(i));
         chk("t4.ser_out", 32'(ser_out), 1);
         chk("t4.underflow", 32'(underflow), 0);
         if (i == 3) en = 1'b0;
         tick();
      end
      chk_idle("t4.idle");
      chk("t4.pend_held", 32'(bus.in_ready), 0);
      tick(); tick();
      chk("t4.still_idle", 32'(ser_valid), 0);
      en = 1'b1;
      #1;
      chk("t4.ready_pop", 32'(bus.in_ready), 1);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t4.w2.valid", 32'(ser_valid), 1);
         chk("t4.w2.ser_out", 32'(ser_out), 0);
         chk("t4.w2.underflow", 32'(underflow), 32'(i == 7));
         tick();
      end
      chk_idle("t4.end");

      // 5 backpressure: only the word held at the accept edge is taken
      s5 = 16'h4411;
      en = 1'b0;
      bus.in_data = 8'h11; bus.in_valid = 1'b1;
      tick();
      bus.in_data = 8'h22;
      #1;
      chk("t5.ready_full", 32'(bus.in_ready), 0);
      tick();
      bus.in_data = 8'h33;
      tick();
      bus.in_data = 8'h44; en = 1'b1;
      #1;
      chk("t5.ready_pop", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("t5.valid", 32'(ser_valid), 1);
         chk("t5.ser_out", 32'(ser_out), 32'(s5[i]));
         chk("t5.word_start", 32'(word_start), 32'((i % 8) == 0));
         chk("t5.underflow", 32'(underflow), 32'(i == 15));
         tick();
      end
      chk_idle("t5.end");

      // 6 reset mid-word discards active and pending words
      bus.in_data = 8'hAA; bus.in_valid = 1'b1;
      tick();
      bus.in_data = 8'h55;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("t6.mux_sel", 32'(mux_sel), 4);
      chk("t6.ser_out", 32'(ser_out), 0);
      rst = 1'b1;
      #1;
      chk("t6.ready_in_rst", 32'(bus.in_ready), 0);
      tick();
      chk_idle("t6.rst");
      chk("t6.ready_in_rst2", 32'(bus.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("t6.ready_after", 32'(bus.in_ready), 1);
      tick(); tick();
      chk_idle("t6.lost");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
